// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one imem request in flight and
// hands each fetched word with its PC to decode; redirects squash wrong-path data.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [63:0] id_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] fetch_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [63:0] pc_reg, pc_next;
  logic        drop_reg, drop_next;
  logic [31:0] inst_q_reg, inst_q_next;
  logic [63:0] pc_q_reg, pc_q_next;
  logic [63:0] fetch_cnt_reg, fetch_cnt_next;
  logic [63:0] redirect_target;

  assign redirect_target = {redirect_pc[63:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      drop_reg      <= 1'b0;
      inst_q_reg    <= 32'd0;
      pc_q_reg      <= 64'd0;
      fetch_cnt_reg <= 64'd0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      drop_reg      <= drop_next;
      inst_q_reg    <= inst_q_next;
      pc_q_reg      <= pc_q_next;
      fetch_cnt_reg <= fetch_cnt_next;
    end
  end

  // A redirect always wins; it only decides whether the in-flight response is squashed.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    drop_next      = drop_reg;
    inst_q_next    = inst_q_reg;
    pc_q_next      = pc_q_reg;
    fetch_cnt_next = fetch_cnt_reg;
    case (state_reg)
      IDLE: begin
        state_next = REQ;
        if (redirect_valid) pc_next = redirect_target;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_next = redirect_target;
          if (imem_req_ready) begin
            state_next = WAIT;
            drop_next  = 1'b1;
          end
        end else if (imem_req_ready) begin
          state_next = WAIT;
          pc_q_next  = pc_reg;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_next = redirect_target;
          if (imem_resp_valid) begin
            state_next = REQ;
            drop_next  = 1'b0;
          end else begin
            drop_next  = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (drop_reg) begin
            state_next = REQ;
            drop_next  = 1'b0;
          end else begin
            state_next  = HOLD;
            inst_q_next = imem_resp_data;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_next    = redirect_target;
          state_next = REQ;
        end else if (id_ready) begin
          pc_next        = pc_q_reg + 64'd4;
          fetch_cnt_next = fetch_cnt_reg + 64'd1;
          state_next     = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign imem_req_valid = (state_reg == REQ);
  assign imem_req_addr  = pc_reg;
  assign id_valid       = (state_reg == HOLD);
  assign id_inst        = inst_q_reg;
  assign id_pc          = pc_q_reg;
  assign fetch_cnt      = fetch_cnt_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run, all
// observed by a transaction-level model of the expected instruction stream.
module tb_fetch_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [63:0] id_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] fetch_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fetch_cnt(fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  // Memory: accepts only when nothing is pending, answers mem_lat cycles later.
  logic        rdy_en = 1'b0;
  int          mem_lat = 1;
  logic        pending = 1'b0;
  int          cd;
  logic [63:0] paddr;
  logic        acc_s;
  logic [63:0] acc_addr;

  assign imem_req_ready = rdy_en && !pending;

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    forever begin
      @(negedge clk);
      acc_s    = imem_req_valid && imem_req_ready && !rst;
      acc_addr = imem_req_addr;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (acc_s) begin
        pending = 1'b1;
        cd      = mem_lat;
        paddr   = acc_addr;
      end
      if (pending) begin
        cd--;
        if (cd == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(paddr);
          pending         = 1'b0;
        end
      end
    end
  end

  // Reference model: the next instruction address the program expects, the number
  // of instructions decode has taken, and whether a fetch is in flight.
  logic [63:0] exp_pc;
  logic [63:0] exp_cnt;
  logic        busy;
  int          idle_cycles;
  int          xfers = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc      = RESET_PC;
        exp_cnt     = 64'd0;
        busy        = 1'b0;
        idle_cycles = 0;
      end else begin
        tests_run++;
        if (fetch_cnt !== exp_cnt) begin
          tests_failed++;
          $display("FAIL sb_fetch_cnt: got %0d expected %0d", fetch_cnt, exp_cnt);
        end
        if (imem_req_valid) begin
          tests_run++;
          if (busy || imem_req_addr !== exp_pc) begin
            tests_failed++;
            $display("FAIL sb_req_addr: got %h (busy=%0b) expected %h", imem_req_addr, busy, exp_pc);
          end
        end
        if (id_valid) begin
          tests_run++;
          if (busy || id_pc !== exp_pc || id_inst !== mem_word(exp_pc)) begin
            tests_failed++;
            $display("FAIL sb_id: got pc %h inst %h expected pc %h inst %h",
                     id_pc, id_inst, exp_pc, mem_word(exp_pc));
          end
        end
        if ((imem_req_valid && imem_req_ready) || (id_valid && id_ready)) idle_cycles = 0;
        else idle_cycles++;
        if (idle_cycles == 40) begin
          tests_run++;
          tests_failed++;
          $display("FAIL sb_watchdog: got %0d idle cycles expected progress", idle_cycles);
        end
        if (imem_resp_valid) busy = 1'b0;
        if (redirect_valid) begin
          exp_pc = {redirect_pc[63:2], 2'b00};
        end else if (id_valid && id_ready) begin
          exp_pc  = exp_pc + 64'd4;
          exp_cnt = exp_cnt + 64'd1;
          xfers++;
        end
        if (imem_req_valid && imem_req_ready) busy = 1'b1;
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; id_ready = 1'b1; rdy_en = 1'b1; mem_lat = 1;
    redirect_valid = 1'b0; redirect_pc = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_inst !== 32'd0 || id_pc !== 64'd0 ||
        fetch_cnt !== 64'd0 || imem_req_addr !== RESET_PC) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rv=%b iv=%b inst=%h pc=%h cnt=%0d addr=%h expected 0 0 0 0 0 %h",
               imem_req_valid, id_valid, id_inst, id_pc, fetch_cnt, imem_req_addr, RESET_PC);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first_cycle: got req_valid %b expected 0", imem_req_valid);
    end
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      tests_failed++;
      $display("FAIL reset_first_req: got valid %b addr %h expected 1 %h",
               imem_req_valid, imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    logic [63:0] a_addr [4];
    int          a_cyc  [4];
    int          n = 0;
    rdy_en = 1'b1; id_ready = 1'b1; mem_lat = 1;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && n < 4) begin
        a_addr[n] = imem_req_addr;
        a_cyc[n]  = i;
        n++;
      end
      if (n >= 3 && fetch_cnt == 64'd3) break;
    end
    tests_run++;
    if (n < 3) begin
      tests_failed++;
      $display("FAIL stream_req_count: got %0d expected >=3", n);
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (a_addr[k] !== RESET_PC + 64'(4 * k)) begin
          tests_failed++;
          $display("FAIL stream_addr%0d: got %h expected %h", k, a_addr[k], RESET_PC + 64'(4 * k));
        end
      end
      tests_run++;
      if (a_cyc[1] - a_cyc[0] != 3 || a_cyc[2] - a_cyc[1] != 3) begin
        tests_failed++;
        $display("FAIL stream_spacing: got %0d,%0d expected 3,3", a_cyc[1] - a_cyc[0], a_cyc[2] - a_cyc[1]);
      end
    end
    tests_run++;
    if (fetch_cnt !== 64'd3) begin
      tests_failed++;
      $display("FAIL stream_fetch_cnt: got %0d expected 3", fetch_cnt);
    end
  endtask

  task automatic test_stall();
    logic [31:0] inst0;
    logic [63:0] pc0, cnt0;
    logic        found = 1'b0;
    @(posedge clk);
    #1;
    id_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id_valid) begin found = 1'b1; break; end
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL stall_wait_valid: got no id_valid expected id_valid within 20 cycles");
    end
    inst0 = id_inst; pc0 = id_pc; cnt0 = fetch_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (id_valid !== 1'b1 || id_inst !== inst0 || id_pc !== pc0 ||
          imem_req_valid !== 1'b0 || fetch_cnt !== cnt0) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: got v=%b inst=%h pc=%h req=%b cnt=%0d expected 1 %h %h 0 %0d",
                 i, id_valid, id_inst, id_pc, imem_req_valid, fetch_cnt, inst0, pc0, cnt0);
      end
    end
    @(posedge clk);
    #1;
    id_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (fetch_cnt !== cnt0 + 64'd1 || id_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_release: got cnt=%0d v=%b expected %0d 0", fetch_cnt, id_valid, cnt0 + 64'd1);
    end
  endtask

  task automatic test_redirect_wait();
    logic found = 1'b0;
    logic saw_id = 1'b0;
    logic [63:0] got_addr = 64'd0;
    rdy_en = 1'b1; id_ready = 1'b1; mem_lat = 4;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) break;
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_1002;
    mem_lat        = 1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id_valid) saw_id = 1'b1;
      if (imem_req_valid && imem_req_ready) begin
        found = 1'b1;
        got_addr = imem_req_addr;
        break;
      end
    end
    tests_run++;
    if (saw_id || !found || got_addr !== 64'h0000_0000_8000_1000) begin
      tests_failed++;
      $display("FAIL redirect_wait: got id_seen=%b req=%b addr=%h expected 0 1 %h",
               saw_id, found, got_addr, 64'h0000_0000_8000_1000);
    end
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id_valid) begin found = 1'b1; break; end
    end
    tests_run++;
    if (!found || id_pc !== 64'h0000_0000_8000_1000 || id_inst !== mem_word(64'h0000_0000_8000_1000)) begin
      tests_failed++;
      $display("FAIL redirect_wait_deliver: got v=%b pc=%h inst=%h expected 1 %h %h",
               found, id_pc, id_inst, 64'h0000_0000_8000_1000, mem_word(64'h0000_0000_8000_1000));
    end
  endtask

  task automatic test_redirect_hold();
    logic        found = 1'b0;
    logic [63:0] cnt0, tgt;
    rdy_en = 1'b1; mem_lat = 1;
    @(posedge clk);
    #1;
    id_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id_valid) begin found = 1'b1; break; end
    end
    cnt0 = fetch_cnt;
    tgt  = {$urandom, $urandom};
    @(posedge clk);
    #1;
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (!found || fetch_cnt !== cnt0 || imem_req_valid !== 1'b1 ||
        imem_req_addr !== {tgt[63:2], 2'b00}) begin
      tests_failed++;
      $display("FAIL redirect_hold: got held=%b cnt=%0d req=%b addr=%h expected 1 %0d 1 %h",
               found, fetch_cnt, imem_req_valid, imem_req_addr, cnt0, {tgt[63:2], 2'b00});
    end
  endtask

  task automatic test_redirect_req();
    logic        found = 1'b0;
    logic [63:0] addr0, tgt;
    id_ready = 1'b1; mem_lat = 1;
    @(posedge clk);
    #1;
    rdy_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin found = 1'b1; break; end
    end
    addr0 = imem_req_addr;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (!found || imem_req_valid !== 1'b1 || imem_req_addr !== addr0) begin
        tests_failed++;
        $display("FAIL redirect_req_stable%0d: got v=%b addr=%h expected 1 %h",
                 i, imem_req_valid, imem_req_addr, addr0);
      end
    end
    tgt = {$urandom, $urandom} | 64'h3;
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    rdy_en         = 1'b1;
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_ready !== 1'b1 || imem_req_addr !== {tgt[63:2], 2'b00}) begin
      tests_failed++;
      $display("FAIL redirect_req_accept: got v=%b rdy=%b addr=%h expected 1 1 %h",
               imem_req_valid, imem_req_ready, imem_req_addr, {tgt[63:2], 2'b00});
    end
  endtask

  task automatic test_reset_wait();
    rdy_en = 1'b1; id_ready = 1'b1; mem_lat = 2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) break;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_lat = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_inst !== 32'd0 || id_pc !== 64'd0 ||
        fetch_cnt !== 64'd0 || imem_req_addr !== RESET_PC) begin
      tests_failed++;
      $display("FAIL reset_wait_outputs: got rv=%b iv=%b inst=%h pc=%h cnt=%0d addr=%h expected 0 0 0 0 0 %h",
               imem_req_valid, id_valid, id_inst, id_pc, fetch_cnt, imem_req_addr, RESET_PC);
    end
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || id_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_wait_restart: got rv=%b addr=%h iv=%b expected 1 %h 0",
               imem_req_valid, imem_req_addr, id_valid, RESET_PC);
    end
  endtask

  task automatic test_random();
    int x0;
    x0 = xfers;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      rdy_en         = ($urandom_range(3) != 0);
      id_ready       = ($urandom_range(9) < 7);
      redirect_valid = ($urandom_range(11) == 0);
      redirect_pc    = {$urandom, $urandom};
      mem_lat        = $urandom_range(3, 1);
      rst            = ($urandom_range(199) == 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; redirect_valid = 1'b0; rdy_en = 1'b1; id_ready = 1'b1; mem_lat = 1;
    repeat (20) @(negedge clk);
    tests_run++;
    if (xfers - x0 < 30) begin
      tests_failed++;
      $display("FAIL random_progress: got %0d transfers expected >=30", xfers - x0);
    end
  endtask

  initial begin
    rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_req();
    test_reset_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
